// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: hazard/redirect requests in, instruction-memory controls
// and the decode-side PC tag out.
interface fetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            stall_i;
  logic            flush_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_target_i;
  logic            imem_rce;
  logic            imem_stall;
  logic            imem_flush;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] id_pc;
  logic            id_valid;
  logic            fault;
  logic [XLEN-1:0] fault_pc;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_target_i,
    output imem_rce, imem_stall, imem_flush, imem_addr,
           id_pc, id_valid, fault, fault_pc
  );

  modport slave (
    output stall_i, flush_i, redirect_i, redirect_target_i,
    input  imem_rce, imem_stall, imem_flush, imem_addr,
           id_pc, id_valid, fault, fault_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the one-cycle synchronous instruction
// memory and tags its output with the PC/valid seen by decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] id_pc_q;
  logic            id_valid_q;
  logic            fault_q;
  logic [XLEN-1:0] fault_pc_q;

  logic            misaligned_c;
  logic            take_fault_c;

  // A misaligned redirect is only acted on when it is not masked by a plain stall.
  always_comb begin
    misaligned_c = bus.redirect_i && (bus.redirect_target_i[1:0] != 2'b00);
    take_fault_c = (state == RUN) && misaligned_c && (bus.flush_i || !bus.stall_i);
  end

  // Memory controls must act in the same cycle as the request, so they decode
  // state and requests directly; imem_addr is always the registered pc.
  always_comb begin
    bus.imem_rce   = 1'b0;
    bus.imem_stall = 1'b0;
    bus.imem_flush = 1'b0;
    unique case (state)
      RUN: begin
        bus.imem_rce   = 1'b1;
        bus.imem_flush = bus.flush_i || take_fault_c;
        bus.imem_stall = bus.stall_i && !bus.flush_i;
      end
      FAULT: begin
        bus.imem_flush = 1'b1;
      end
      default: begin
        bus.imem_rce = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state <= RUN;
        end

        RUN: begin
          if (take_fault_c) begin
            // Stop fetching for good; pc and id_pc freeze for post-mortem.
            state      <= FAULT;
            fault_q    <= 1'b1;
            fault_pc_q <= bus.redirect_target_i;
            id_valid_q <= 1'b0;
          end else if (bus.flush_i) begin
            id_valid_q <= 1'b0;
            if (bus.redirect_i) begin
              pc <= bus.redirect_target_i;
            end
          end else if (bus.stall_i) begin
            pc         <= pc;
            id_pc_q    <= id_pc_q;
            id_valid_q <= id_valid_q;
          end else begin
            // Current fetch completes (delay slot when redirecting).
            id_pc_q    <= pc;
            id_valid_q <= 1'b1;
            if (bus.redirect_i) begin
              pc <= bus.redirect_target_i;
            end else begin
              pc <= XLEN'(pc + XLEN'(PC_STEP));
            end
          end
        end

        FAULT: begin
          id_valid_q <= 1'b0;
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  assign bus.imem_addr = pc;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.fault     = fault_q;
  assign bus.fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed table from the test plan, a wrap-around
// instance, then randomized requests checked against a cycle-level model.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_ctrl_if ifc ();
  fetch_ctrl_if ifw ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(ifc));
  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (.clk(clk), .rst(rst), .bus(ifw));

  typedef struct {
    logic        rst, stall, flush, redir;
    logic [31:0] tgt;
    logic [31:0] addr, idpc;
    logic        valid, rce, mstall, mflush, fault;
    logic [31:0] fpc;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: architectural view of the fetch unit.
  typedef enum int {M_BOOT, M_RUN, M_FAULT} mmode_t;
  mmode_t      m_mode;
  logic [31:0] m_pc, m_idpc, m_fpc;
  logic        m_valid, m_fault;

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic rd,
                              input logic [31:0] t, input logic [31:0] a, input logic [31:0] ip,
                              input logic v, input logic rce, input logic ms, input logic mf,
                              input logic flt, input logic [31:0] fp);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.redir = rd; x.tgt = t;
    x.addr = a; x.idpc = ip; x.valid = v; x.rce = rce; x.mstall = ms;
    x.mflush = mf; x.fault = flt; x.fpc = fp;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input vec_t v);
    logic bad;
    bad = v.redir && (v.tgt % 4 != 0);
    if (v.rst) begin
      m_mode = M_BOOT; m_pc = 32'h0; m_idpc = 32'h0; m_valid = 1'b0;
      m_fault = 1'b0; m_fpc = 32'h0;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (v.flush || (!v.stall && v.redir)) begin
        if (v.redir && bad) begin
          m_mode = M_FAULT; m_fault = 1'b1; m_fpc = v.tgt; m_valid = 1'b0;
        end else if (v.flush) begin
          m_valid = 1'b0;
          if (v.redir) m_pc = v.tgt;
        end else begin
          m_idpc = m_pc; m_valid = 1'b1; m_pc = v.tgt;
        end
      end else if (!v.stall) begin
        m_idpc = m_pc; m_valid = 1'b1; m_pc = 32'(m_pc + 32'd4);
      end
    end
  endtask

  function automatic vec_t model_exp(input vec_t v);
    vec_t e;
    logic bad;
    e = v;
    bad = v.redir && (v.tgt % 4 != 0);
    e.addr = m_pc; e.idpc = m_idpc; e.valid = m_valid;
    e.fault = m_fault; e.fpc = m_fpc;
    e.rce = (m_mode == M_RUN);
    e.mstall = (m_mode == M_RUN) && v.stall && !v.flush;
    e.mflush = (m_mode == M_FAULT) ||
               ((m_mode == M_RUN) && (v.flush || (bad && !v.stall)));
    return e;
  endfunction

  task automatic step(input vec_t v, input bit use_tbl, input bit do_chk);
    vec_t e;
    @(negedge clk);
    rst = v.rst;
    ifc.stall_i = v.stall; ifc.flush_i = v.flush;
    ifc.redirect_i = v.redir; ifc.redirect_target_i = v.tgt;
    #1;
    e = use_tbl ? v : model_exp(v);
    if (do_chk) begin
      chk("imem_addr",  ifc.imem_addr, e.addr);
      chk("id_pc",      ifc.id_pc, e.idpc);
      chk("id_valid",   32'(ifc.id_valid), 32'(e.valid));
      chk("imem_rce",   32'(ifc.imem_rce), 32'(e.rce));
      chk("imem_stall", 32'(ifc.imem_stall), 32'(e.mstall));
      chk("imem_flush", 32'(ifc.imem_flush), 32'(e.mflush));
      chk("fault",      32'(ifc.fault), 32'(e.fault));
      chk("fault_pc",   ifc.fault_pc, e.fpc);
    end
    model_step(v);
    cyc++;
  endtask

  vec_t        tbl[21];
  logic [31:0] wrap_exp[5];

  initial begin
    vec_t r;
    rst = 1'b1;
    ifc.stall_i = 1'b0; ifc.flush_i = 1'b0; ifc.redirect_i = 1'b0; ifc.redirect_target_i = '0;
    ifw.stall_i = 1'b0; ifw.flush_i = 1'b0; ifw.redirect_i = 1'b0; ifw.redirect_target_i = '0;

    //             rst s f rd tgt            addr          idpc          v rce ms mf flt fpc
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,   32'h0,  32'h0,  0, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 32'h0,   32'h0,  32'h0,  0, 1, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h0,   32'h4,  32'h0,  1, 1, 0, 0, 0, 32'h0);
    tbl[3]  = mk(0, 1, 0, 0, 32'h0,   32'h8,  32'h4,  1, 1, 1, 0, 0, 32'h0);
    tbl[4]  = mk(0, 1, 0, 1, 32'h200, 32'h8,  32'h4,  1, 1, 1, 0, 0, 32'h0);
    tbl[5]  = mk(0, 1, 0, 0, 32'h0,   32'h8,  32'h4,  1, 1, 1, 0, 0, 32'h0);
    tbl[6]  = mk(0, 0, 0, 0, 32'h0,   32'h8,  32'h4,  1, 1, 0, 0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 0, 0, 32'h0,   32'hC,  32'h8,  1, 1, 0, 0, 0, 32'h0);
    tbl[8]  = mk(0, 0, 0, 1, 32'h40,  32'h10, 32'hC,  1, 1, 0, 0, 0, 32'h0);
    tbl[9]  = mk(0, 0, 0, 0, 32'h0,   32'h40, 32'h10, 1, 1, 0, 0, 0, 32'h0);
    tbl[10] = mk(0, 0, 0, 0, 32'h0,   32'h44, 32'h40, 1, 1, 0, 0, 0, 32'h0);
    tbl[11] = mk(0, 0, 0, 1, 32'h20,  32'h48, 32'h44, 1, 1, 0, 0, 0, 32'h0);
    tbl[12] = mk(0, 1, 1, 1, 32'h80,  32'h20, 32'h48, 1, 1, 0, 1, 0, 32'h0);
    tbl[13] = mk(0, 0, 0, 0, 32'h0,   32'h80, 32'h48, 0, 1, 0, 0, 0, 32'h0);
    tbl[14] = mk(0, 0, 0, 0, 32'h0,   32'h84, 32'h80, 1, 1, 0, 0, 0, 32'h0);
    tbl[15] = mk(0, 0, 0, 1, 32'h42,  32'h88, 32'h84, 1, 1, 0, 1, 0, 32'h0);
    tbl[16] = mk(0, 0, 0, 0, 32'h0,   32'h88, 32'h84, 0, 0, 0, 1, 1, 32'h42);
    tbl[17] = mk(0, 1, 1, 1, 32'h100, 32'h88, 32'h84, 0, 0, 0, 1, 1, 32'h42);
    tbl[18] = mk(1, 0, 0, 0, 32'h0,   32'h88, 32'h84, 0, 0, 0, 1, 1, 32'h42);
    tbl[19] = mk(0, 0, 0, 0, 32'h0,   32'h0,  32'h0,  0, 0, 0, 0, 0, 32'h0);
    tbl[20] = mk(0, 0, 0, 0, 32'h0,   32'h0,  32'h0,  0, 1, 0, 0, 0, 32'h0);

    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFF8;
    wrap_exp[2] = 32'hFFFF_FFFC; wrap_exp[3] = 32'h0000_0000;
    wrap_exp[4] = 32'h0000_0004;

    r = mk(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    step(r, 1'b1, 1'b0);
    step(r, 1'b1, 1'b0);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i], 1'b1, 1'b1);
      if (i < 5) chk("wrap_imem_addr", ifw.imem_addr, wrap_exp[i]);
    end

    step(r, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v = r;
      v.rst   = (m_mode == M_FAULT) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.flush = ($urandom_range(0, 9) == 0);
      v.redir = ($urandom_range(0, 3) == 0);
      v.tgt   = {$urandom(), 2'b00} >> 2 << 2;
      v.tgt   = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 29) == 0) v.tgt[1:0] = 2'($urandom_range(1, 3));
      step(v, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
